regfile_controller: RTL and testbench

REGFILE_CONTROLLER -- requirements
Module: regfile_controller

---
 rtl/regfile_pkg.sv | 42 ++++
 rtl/regfile_controller_if.sv | 33 +++
 rtl/rf_alu.sv | 55 +++++
 rtl/regfile_controller.sv | 123 ++++++++++++
 tb/tb_regfile_controller.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file controller: instruction field
// layout, opcode values, FSM state encoding and opcode classification helpers.
package regfile_pkg;

   localparam int OPC_LSB  = 16;
   localparam int DST_LSB  = 12;
   localparam int SRCA_LSB = 8;
   localparam int SRCB_LSB = 4;
   localparam int IMM_LSB  = 0;
   localparam int OPC_W    = 4;
   localparam int IMM_W    = 12;

   typedef enum logic [3:0] {
      OP_NOP = 4'd0,
      OP_ADD = 4'd1,
      OP_SUB = 4'd2,
      OP_AND = 4'd3,
      OP_OR  = 4'd4,
      OP_XOR = 4'd5,
      OP_MOV = 4'd6,
      OP_SHL = 4'd7,
      OP_SHR = 4'd8,
      OP_LDI = 4'd9
   } opcode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WRB  = 2'd3
   } state_t;

   // Opcodes 1..9 produce a register result and update the flags.
   function automatic logic is_writeback(input logic [3:0] op);
      return (op >= 4'd1) && (op <= 4'd9);
   endfunction

   function automatic logic is_illegal(input logic [3:0] op);
      return op >= 4'd10;
   endfunction

endpackage

// File: rtl/regfile_controller_if.sv
// Instruction handshake and register-file port bundle. The master side offers
// instructions and returns read data; the slave side is the controller.
interface regfile_controller_if #(
   parameter int DATA_W = 20,
   parameter int ADDR_W = 4
);
   logic [DATA_W-1:0] instr;
   logic              instr_valid;
   logic              instr_ready;
   logic [ADDR_W-1:0] rdAddrA;
   logic [ADDR_W-1:0] rdAddrB;
   logic [DATA_W-1:0] rdDataA;
   logic [DATA_W-1:0] rdDataB;
   logic              write;
   logic [ADDR_W-1:0] wrAddr;
   logic [DATA_W-1:0] wrData;
   logic              done;
   logic              illegal;
   logic              zero;
   logic              carry;

   modport master (
      output instr, instr_valid, rdDataA, rdDataB,
      input  instr_ready, rdAddrA, rdAddrB, write, wrAddr, wrData,
             done, illegal, zero, carry
   );

   modport slave (
      input  instr, instr_valid, rdDataA, rdDataB,
      output instr_ready, rdAddrA, rdAddrB, write, wrAddr, wrData,
             done, illegal, zero, carry
   );
endinterface

// File: rtl/rf_alu.sv
// Combinational ALU: computes the result and carry for one opcode; zero is
// derived from the wrapped result.
module rf_alu
   import regfile_pkg::*;
#(
   parameter int DATA_W = 20
) (
   input  opcode_t           opcode,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [IMM_W-1:0]  imm,
   output logic [DATA_W-1:0] result,
   output logic              carry,
   output logic              zero
);

   logic [DATA_W:0] sum_s;

   assign sum_s = {1'b0, a} + {1'b0, b};

   // Opcode decode; undefined opcodes yield a zero result and clear carry.
   always_comb begin
      result = {DATA_W{1'b0}};
      carry  = 1'b0;
      case (opcode)
         OP_ADD: begin
            result = sum_s[DATA_W-1:0];
            carry  = sum_s[DATA_W];
         end
         OP_SUB: begin
            result = a - b;
            carry  = (a < b);
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_MOV: result = a;
         OP_SHL: begin
            result = {a[DATA_W-2:0], 1'b0};
            carry  = a[DATA_W-1];
         end
         OP_SHR: begin
            result = {1'b0, a[DATA_W-1:1]};
            carry  = a[0];
         end
         OP_LDI: result = {{(DATA_W-IMM_W){1'b0}}, imm};
         default: begin
            result = {DATA_W{1'b0}};
            carry  = 1'b0;
         end
      endcase
      zero = (result == {DATA_W{1'b0}});
   end

endmodule

// File: rtl/regfile_controller.sv
// Four-phase instruction controller (IDLE, READ, EXEC, WRB) driving an
// external register file; accepts one instruction per four cycles.
module regfile_controller
   import regfile_pkg::*;
#(
   parameter int DATA_W = 20,
   parameter int ADDR_W = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   regfile_controller_if.slave bus
);

   state_t            state_r;
   state_t            state_s;
   logic              ready_r;
   logic              accept_s;
   logic [DATA_W-1:0] instr_r;
   opcode_t           opcode_s;
   logic [ADDR_W-1:0] rd_addr_a_r;
   logic [ADDR_W-1:0] rd_addr_b_r;
   logic              write_r;
   logic [ADDR_W-1:0] wr_addr_r;
   logic [DATA_W-1:0] wr_data_r;
   logic              done_r;
   logic              illegal_r;
   logic              zero_r;
   logic              carry_r;
   logic [DATA_W-1:0] alu_result_s;
   logic              alu_carry_s;
   logic              alu_zero_s;

   assign accept_s = ready_r & bus.instr_valid;
   assign opcode_s = opcode_t'(instr_r[OPC_LSB +: OPC_W]);

   rf_alu #(.DATA_W(DATA_W)) u_alu (
      .opcode (opcode_s),
      .a      (bus.rdDataA),
      .b      (bus.rdDataB),
      .imm    (instr_r[IMM_LSB +: IMM_W]),
      .result (alu_result_s),
      .carry  (alu_carry_s),
      .zero   (alu_zero_s)
   );

   // Next-state logic: every phase lasts exactly one cycle once accepted.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_s = ST_READ;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_READ: state_s = ST_EXEC;
         ST_EXEC: state_s = ST_WRB;
         ST_WRB:  state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // State register; ready is registered from the next state so it tracks IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         ready_r <= 1'b1;
      end else begin
         state_r <= state_s;
         ready_r <= (state_s == ST_IDLE);
      end
   end

   // Datapath: capture on accept, latch ALU outcome at the end of EXEC so the
   // write, retire pulses and flags are all visible during WRB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_r     <= {DATA_W{1'b0}};
         rd_addr_a_r <= {ADDR_W{1'b0}};
         rd_addr_b_r <= {ADDR_W{1'b0}};
         write_r     <= 1'b0;
         wr_addr_r   <= {ADDR_W{1'b0}};
         wr_data_r   <= {DATA_W{1'b0}};
         done_r      <= 1'b0;
         illegal_r   <= 1'b0;
         zero_r      <= 1'b0;
         carry_r     <= 1'b0;
      end else begin
         write_r   <= 1'b0;
         done_r    <= 1'b0;
         illegal_r <= 1'b0;
         if (accept_s) begin
            instr_r     <= bus.instr;
            rd_addr_a_r <= bus.instr[SRCA_LSB +: ADDR_W];
            rd_addr_b_r <= bus.instr[SRCB_LSB +: ADDR_W];
         end
         if (state_r == ST_EXEC) begin
            done_r    <= 1'b1;
            illegal_r <= is_illegal(opcode_s);
            if (is_writeback(opcode_s)) begin
               write_r   <= 1'b1;
               wr_addr_r <= instr_r[DST_LSB +: ADDR_W];
               wr_data_r <= alu_result_s;
               zero_r    <= alu_zero_s;
               carry_r   <= alu_carry_s;
            end
         end
      end
   end

   assign bus.instr_ready = ready_r;
   assign bus.rdAddrA     = rd_addr_a_r;
   assign bus.rdAddrB     = rd_addr_b_r;
   assign bus.write       = write_r;
   assign bus.wrAddr      = wr_addr_r;
   assign bus.wrData      = wr_data_r;
   assign bus.done        = done_r;
   assign bus.illegal     = illegal_r;
   assign bus.zero        = zero_r;
   assign bus.carry       = carry_r;

endmodule

// File: tb/tb_regfile_controller.sv
// Randomized bench for regfile_controller: a behavioural ISA model predicts
// register contents, flags and retire pulses for every accepted instruction.
module tb_regfile_controller;

   localparam int unsigned MOD = 32'd1048576;

   logic clk;
   logic rst_n;

   regfile_controller_if #(.DATA_W(20), .ADDR_W(4)) bus ();

   regfile_controller #(.DATA_W(20), .ADDR_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Register file attached to the controller, with a backdoor preload port.
   logic [19:0] rf_mem [16];
   logic        pre_en;
   logic [3:0]  pre_idx;
   logic [19:0] pre_val;

   assign bus.rdDataA = rf_mem[bus.rdAddrA];
   assign bus.rdDataB = rf_mem[bus.rdAddrB];

   always @(posedge clk) begin
      if (pre_en) rf_mem[pre_idx] <= pre_val;
      else if (bus.write) rf_mem[bus.wrAddr] <= bus.wrData;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   int unsigned model_regs [16];
   bit          model_zero;
   bit          model_carry;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ISA semantics: 20-bit wrapping arithmetic, flags only for opcodes 1..9.
   task automatic model_apply(input logic [19:0] iw, output bit wb,
                              output int unsigned res, output bit ill);
      int unsigned op, dst, a, b, imm, full;
      bit c;
      op  = iw[19:16];
      dst = iw[15:12];
      a   = model_regs[iw[11:8]];
      b   = model_regs[iw[7:4]];
      imm = iw[11:0];
      wb  = (op >= 1) && (op <= 9);
      ill = (op >= 10);
      res = 0;
      c   = 1'b0;
      case (op)
         1: begin full = a + b; res = full % MOD; c = (full >= MOD); end
         2: begin res = (a + MOD - b) % MOD; c = (a < b); end
         3: res = a & b;
         4: res = a | b;
         5: res = a ^ b;
         6: res = a;
         7: begin res = (a * 2) % MOD; c = (a >= MOD / 2); end
         8: begin res = a / 2; c = (a % 2) == 1; end
         9: res = imm;
         default: res = 0;
      endcase
      if (wb) begin
         model_regs[dst] = res;
         model_zero      = (res == 0);
         model_carry     = c;
      end
   endtask

   task automatic preload(input int idx, input int unsigned val);
      @(negedge clk);
      pre_en  = 1'b1;
      pre_idx = idx[3:0];
      pre_val = val[19:0];
      model_regs[idx] = val;
      @(negedge clk);
      pre_en = 1'b0;
   endtask

   task automatic run_instr(input logic [19:0] iw);
      int          guard;
      bit          wb, ill;
      int unsigned res;
      guard = 0;
      @(negedge clk);
      while (!bus.instr_ready && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      check("ready_wait", {31'd0, bus.instr_ready}, 32'd1);
      bus.instr       = iw;
      bus.instr_valid = 1'b1;
      model_apply(iw, wb, res, ill);
      @(negedge clk);
      // Offered-but-not-ready garbage must not be captured.
      bus.instr_valid = 1'b0;
      bus.instr       = 20'($urandom);
      check("read_ready", {31'd0, bus.instr_ready}, 32'd0);
      check("read_addra", {28'd0, bus.rdAddrA}, {28'd0, iw[11:8]});
      check("read_addrb", {28'd0, bus.rdAddrB}, {28'd0, iw[7:4]});
      check("read_write", {31'd0, bus.write}, 32'd0);
      bus.instr_valid = 1'b1;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      check("exec_done", {31'd0, bus.done}, 32'd0);
      check("exec_addra", {28'd0, bus.rdAddrA}, {28'd0, iw[11:8]});
      @(negedge clk);
      check("wrb_write", {31'd0, bus.write}, {31'd0, wb});
      check("wrb_done", {31'd0, bus.done}, 32'd1);
      check("wrb_illegal", {31'd0, bus.illegal}, {31'd0, ill});
      if (wb) begin
         check("wrb_addr", {28'd0, bus.wrAddr}, {28'd0, iw[15:12]});
         check("wrb_data", {12'd0, bus.wrData}, res);
      end
      check("wrb_zero", {31'd0, bus.zero}, {31'd0, model_zero});
      check("wrb_carry", {31'd0, bus.carry}, {31'd0, model_carry});
      @(negedge clk);
      check("post_done", {31'd0, bus.done}, 32'd0);
      check("post_illegal", {31'd0, bus.illegal}, 32'd0);
      check("post_write", {31'd0, bus.write}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int accepts, last;
      bit took;
      bit wb, ill;
      int unsigned res;
      rst_n           = 1'b0;
      bus.instr       = 20'd0;
      bus.instr_valid = 1'b0;
      pre_en          = 1'b0;
      pre_idx         = 4'd0;
      pre_val         = 20'd0;
      model_zero      = 1'b0;
      model_carry     = 1'b0;
      for (int i = 0; i < 16; i++) preload(i, $urandom_range(0, 32'hFFFFF));

      @(negedge clk);
      bus.instr_valid = 1'b1;
      check("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
      check("rst_write", {31'd0, bus.write}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_illegal", {31'd0, bus.illegal}, 32'd0);
      check("rst_zero", {31'd0, bus.zero}, 32'd0);
      check("rst_carry", {31'd0, bus.carry}, 32'd0);
      check("rst_wraddr", {28'd0, bus.wrAddr}, 32'd0);
      check("rst_wrdata", {12'd0, bus.wrData}, 32'd0);
      check("rst_rdaddra", {28'd0, bus.rdAddrA}, 32'd0);
      check("rst_rdaddrb", {28'd0, bus.rdAddrB}, 32'd0);
      bus.instr_valid = 1'b0;
      rst_n = 1'b1;

      run_instr({4'd9, 4'd3, 12'h123});
      check("ldi_r3", {12'd0, rf_mem[3]}, 32'h00123);

      preload(1, 32'hFFFFF);
      preload(2, 32'h00001);
      run_instr({4'd1, 4'd4, 4'd1, 4'd2, 4'd0});
      check("add_r4", {12'd0, rf_mem[4]}, 32'h00000);
      check("add_carry", {31'd0, bus.carry}, 32'd1);
      check("add_zero", {31'd0, bus.zero}, 32'd1);

      preload(1, 32'h00002);
      run_instr({4'd2, 4'd5, 4'd2, 4'd1, 4'd0});
      check("sub_r5", {12'd0, rf_mem[5]}, 32'hFFFFF);
      check("sub_carry", {31'd0, bus.carry}, 32'd1);
      check("sub_zero", {31'd0, bus.zero}, 32'd0);

      run_instr({4'd12, 16'($urandom)});
      check("ill_carry", {31'd0, bus.carry}, 32'd1);
      check("ill_zero", {31'd0, bus.zero}, 32'd0);

      // Abort an ADD in EXEC with an asynchronous reset.
      preload(6, 32'h5A5A5);
      @(negedge clk);
      bus.instr       = {4'd1, 4'd6, 4'd1, 4'd2, 4'd0};
      bus.instr_valid = 1'b1;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_ready", {31'd0, bus.instr_ready}, 32'd1);
      check("abort_write", {31'd0, bus.write}, 32'd0);
      @(negedge clk);
      rst_n       = 1'b1;
      model_zero  = 1'b0;
      model_carry = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("abort_nowrite", {31'd0, bus.write}, 32'd0);
         check("abort_nodone", {31'd0, bus.done}, 32'd0);
      end
      check("abort_r6", {12'd0, rf_mem[6]}, 32'h5A5A5);
      run_instr({4'd1, 4'd7, 4'd1, 4'd2, 4'd0});
      check("after_abort_r7", {12'd0, rf_mem[7]}, 32'h00003);

      // Back-to-back offers: one accept every fourth cycle.
      accepts = 0;
      last    = -1;
      took    = 1'b0;
      bus.instr       = 20'($urandom);
      bus.instr_valid = 1'b1;
      for (int cyc = 0; cyc < 24; cyc++) begin
         @(negedge clk);
         if (took) begin
            bus.instr = 20'($urandom);
            took = 1'b0;
         end
         if (bus.instr_ready) begin
            model_apply(bus.instr, wb, res, ill);
            if (last >= 0) check("tput_gap", cyc - last, 32'd4);
            last = cyc;
            accepts++;
            took = 1'b1;
         end
      end
      bus.instr_valid = 1'b0;
      check("tput_accepts", accepts, 32'd6);
      repeat (5) @(negedge clk);
      for (int i = 0; i < 16; i++) check("tput_reg", {12'd0, rf_mem[i]}, model_regs[i]);
      check("tput_zero", {31'd0, bus.zero}, {31'd0, model_zero});
      check("tput_carry", {31'd0, bus.carry}, {31'd0, model_carry});

      for (int n = 0; n < 40; n++) run_instr(20'($urandom));
      for (int i = 0; i < 16; i++) check("final_reg", {12'd0, rf_mem[i]}, model_regs[i]);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
